// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-stage hazard controller for the architectural register file.
//   Each register n (n != 0) has a small saturating count of outstanding
//   writes. Decode is stalled while a source operand still has a pending
//   write (with optional same-cycle writeback bypass) or while the
//   destination's counter is already full. Writeback and squash each
//   release one pending write.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   issueValid               decode presents an instruction
//   useRs/issueRs            first source operand enable / index
//   useRt/issueRt            second source operand enable / index
//   issueWrite/issueDst      destination write enable / index
//   wbValid/wbIdx            writeback-stage register write
//   killValid/killIdx        squash of an in-flight writer (release only)
//   stall                    combinational: decode must hold
//   issueAccept              combinational: issueValid & ~stall
//   busyMask                 registered: bit n = counter[n] != 0
//   errUnderflow             registered, sticky: release hit a zero counter
//   stallCount               registered, saturating count of stalled cycles
module reg_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issueValid,
  input  logic                useRs,
  input  logic                useRt,
  input  logic [IDX_W-1:0]    issueRs,
  input  logic [IDX_W-1:0]    issueRt,
  input  logic                issueWrite,
  input  logic [IDX_W-1:0]    issueDst,
  input  logic                wbValid,
  input  logic [IDX_W-1:0]    wbIdx,
  input  logic                killValid,
  input  logic [IDX_W-1:0]    killIdx,
  output logic                stall,
  output logic                issueAccept,
  output logic [NUM_REGS-1:0] busyMask,
  output logic                errUnderflow,
  output logic [15:0]         stallCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cntNext [NUM_REGS];
  logic [NUM_REGS-1:0] busyNext;
  logic                underflowNext;
  logic                rsReady;
  logic                rtReady;
  logic                dstBlock;

  // A source is ready when unused, r0, idle, or (bypass) its last pending
  // write retires this very cycle. Kill never bypasses: it writes nothing.
  function automatic logic srcReady(input logic             useSrc,
                                    input logic [IDX_W-1:0] idx,
                                    input logic [CNT_W-1:0] c,
                                    input logic             wbHit);
    return !useSrc || (idx == '0) || (c == '0) ||
           ((WB_BYPASS != 0) && (c == CNT_W'(1)) && wbHit);
  endfunction

  always_comb begin
    rsReady     = srcReady(useRs, issueRs, cnt[issueRs], wbValid && (wbIdx == issueRs));
    rtReady     = srcReady(useRt, issueRt, cnt[issueRt], wbValid && (wbIdx == issueRt));
    // A release to the destination in the same cycle deliberately does not
    // unblock it; this keeps the full check off the writeback path.
    dstBlock    = issueWrite && (issueDst != '0) && (cnt[issueDst] == CNT_MAX);
    stall       = issueValid && (!rsReady || !rtReady || dstBlock);
    issueAccept = issueValid && !stall;
  end

  // Per-register next count: count + inc - relWb - relKill, clamped at 0.
  // inc is only possible when the counter is below max, so no overflow.
  always_comb begin
    logic [CNT_W:0] sum;
    logic [CNT_W:0] rel;
    underflowNext = 1'b0;
    busyNext      = '0;
    sum           = '0;
    rel           = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      cntNext[n] = '0;
      if (n != 0) begin
        sum = {1'b0, cnt[n]} +
              (CNT_W+1)'(issueAccept && issueWrite && (issueDst == IDX_W'(n)));
        rel = (CNT_W+1)'(wbValid && (wbIdx == IDX_W'(n))) +
              (CNT_W+1)'(killValid && (killIdx == IDX_W'(n)));
        if (rel > sum) begin
          cntNext[n]    = '0;
          underflowNext = 1'b1;
        end else begin
          cntNext[n] = CNT_W'(sum - rel);
        end
      end
      busyNext[n] = (cntNext[n] != '0);
    end
  end

  // State update boundary: counters, busy mask, error flag, stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_REGS; n++) cnt[n] <= '0;
      busyMask     <= '0;
      errUnderflow <= 1'b0;
      stallCount   <= '0;
    end else begin
      for (int n = 0; n < NUM_REGS; n++) cnt[n] <= cntNext[n];
      busyMask <= busyNext;
      if (underflowNext) errUnderflow <= 1'b1;
      if (issueValid && stall && (stallCount != 16'hFFFF))
        stallCount <= stallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        issueValid, useRs, useRt, issueWrite, wbValid, killValid;
  logic [4:0]  issueRs, issueRt, issueDst, wbIdx, killIdx;
  logic        stall, issueAccept, errUnderflow;
  logic [31:0] busyMask;
  logic [15:0] stallCount;

  int errors = 0;
  int checks = 0;

  // Reference model state: pending-write count per register as plain ints.
  int mc[NR];
  int msc   = 0;
  bit merr  = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(32), .IDX_W(5), .CNT_W(2), .WB_BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .issueValid(issueValid), .useRs(useRs), .useRt(useRt),
    .issueRs(issueRs), .issueRt(issueRt),
    .issueWrite(issueWrite), .issueDst(issueDst),
    .wbValid(wbValid), .wbIdx(wbIdx),
    .killValid(killValid), .killIdx(killIdx),
    .stall(stall), .issueAccept(issueAccept), .busyMask(busyMask),
    .errUnderflow(errUnderflow), .stallCount(stallCount)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit mReady(input logic u, input logic [4:0] idx);
    if (!u || idx == 0) return 1;
    if (mc[idx] == 0) return 1;
    if (mc[idx] == 1 && wbValid && wbIdx == idx) return 1;
    return 0;
  endfunction

  // Compare process: check every cycle against the model, then advance it.
  initial begin
    for (int n = 0; n < NR; n++) mc[n] = 0;
    forever begin
      @(negedge clk);
      begin
        bit          eStall, eAcc;
        logic [31:0] eBusy;
        int          v;
        eStall = issueValid && (!mReady(useRs, issueRs) || !mReady(useRt, issueRt) ||
                                (issueWrite && issueDst != 0 && mc[issueDst] == 3));
        eAcc   = issueValid && !eStall;
        eBusy  = '0;
        for (int n = 1; n < NR; n++) eBusy[n] = (mc[n] != 0);
        if (armed) begin
          chk("stall", 32'(stall), 32'(eStall));
          chk("issueAccept", 32'(issueAccept), 32'(eAcc));
          chk("busyMask", busyMask, eBusy);
          chk("errUnderflow", 32'(errUnderflow), 32'(merr));
          chk("stallCount", 32'(stallCount), 32'(msc));
        end
        if (reset) begin
          for (int n = 0; n < NR; n++) mc[n] = 0;
          msc   = 0;
          merr  = 0;
          armed = 1;
        end else if (armed) begin
          for (int n = 1; n < NR; n++) begin
            v = mc[n];
            if (eAcc && issueWrite && issueDst == n) v++;
            if (wbValid && wbIdx == n) v--;
            if (killValid && killIdx == n) v--;
            if (v < 0) begin merr = 1; v = 0; end
            mc[n] = v;
          end
          if (eStall && msc < 65535) msc++;
        end
      end
    end
  end

  task automatic idle();
    issueValid = 0; useRs = 0; useRt = 0; issueRs = 0; issueRt = 0;
    issueWrite = 0; issueDst = 0; wbValid = 0; wbIdx = 0; killValid = 0; killIdx = 0;
  endtask

  task automatic nx();
    @(posedge clk); #2; idle();
  endtask

  task automatic go();
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] d);
    issueValid = 1; issueWrite = 1; issueDst = d;
  endtask

  task automatic rd(input logic [4:0] s);
    issueValid = 1; useRs = 1; issueRs = s;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #2; reset = 0;
    go();
    chk("rst_busy", busyMask, 32'h0);
    chk("rst_err", 32'(errUnderflow), 32'h0);
    chk("rst_stallCount", 32'(stallCount), 32'h0);

    // RAW on r3 with writeback bypass
    nx(); wr(3); go(); chk("raw_accept", 32'(issueAccept), 32'h1);
    for (int i = 0; i < 3; i++) begin
      nx(); rd(3); go(); chk("raw_stall", 32'(stall), 32'h1);
      if (i == 0) chk("raw_busy3", 32'(busyMask[3]), 32'h1);
    end
    nx(); rd(3); wbValid = 1; wbIdx = 3; go();
    chk("raw_bypass_stall", 32'(stall), 32'h0);
    chk("raw_stallCount", 32'(stallCount), 32'd3);
    nx(); go(); chk("raw_busy_clear", busyMask, 32'h0);

    // WAW on r5: counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      nx(); wr(5); go(); chk("waw_accept", 32'(issueAccept), 32'h1);
    end
    nx(); wr(5); go(); chk("waw_full_stall", 32'(stall), 32'h1);
    nx(); wr(5); wbValid = 1; wbIdx = 5; go(); chk("waw_same_cycle_rel", 32'(stall), 32'h1);
    nx(); wr(5); go(); chk("waw_4th_accept", 32'(issueAccept), 32'h1);
    for (int i = 0; i < 3; i++) begin
      nx(); wbValid = 1; wbIdx = 5; go(); chk("waw_busy_held", 32'(busyMask[5]), 32'h1);
    end
    nx(); go(); chk("waw_busy_clear", busyMask, 32'h0);

    // r0 is never tracked
    nx(); wr(0); rd(0); useRt = 1; issueRt = 0; go(); chk("r0_stall", 32'(stall), 32'h0);
    nx(); wbValid = 1; wbIdx = 0; killValid = 1; killIdx = 0; go();
    chk("r0_busy", busyMask, 32'h0);
    nx(); go(); chk("r0_err", 32'(errUnderflow), 32'h0);

    // Flush via kills, then an extra kill underflows
    nx(); wr(7); go();
    nx(); wr(8); go();
    nx(); killValid = 1; killIdx = 7; go();
    nx(); killValid = 1; killIdx = 8; go(); chk("flush_busy_mid", busyMask, 32'h100);
    nx(); go(); chk("flush_busy", busyMask, 32'h0); chk("flush_err0", 32'(errUnderflow), 32'h0);
    nx(); killValid = 1; killIdx = 7; go();
    nx(); rd(7); go();
    chk("uf_err", 32'(errUnderflow), 32'h1);
    chk("uf_busy", busyMask, 32'h0);
    chk("uf_no_stall", 32'(stall), 32'h0);
    nx(); go(); chk("uf_sticky", 32'(errUnderflow), 32'h1);

    nx(); reset = 1; go();
    nx(); reset = 0; go(); chk("rst_err_clear", 32'(errUnderflow), 32'h0);

    // Simultaneous issue and release on r9
    nx(); wr(9); go();
    nx(); wr(9); wbValid = 1; wbIdx = 9; go(); chk("sim_accept", 32'(issueAccept), 32'h1);
    nx(); wr(9); go();
    nx(); wbValid = 1; wbIdx = 9; killValid = 1; killIdx = 9; go();
    chk("sim_busy9", busyMask, 32'h200);
    nx(); go();
    chk("sim_busy_clear", busyMask, 32'h0);
    chk("sim_err", 32'(errUnderflow), 32'h0);

    // Reset mid-operation
    nx(); wr(3); go();
    nx(); wr(4); go();
    nx(); wr(8); go();
    for (int i = 0; i < 5; i++) begin nx(); rd(3); go(); end
    nx(); go();
    chk("mid_busy", busyMask, 32'h0000_0118);
    chk("mid_stallCount", 32'(stallCount), 32'd5);
    nx(); reset = 1; wbValid = 1; wbIdx = 3; go();
    nx(); reset = 0; rd(3); go();
    chk("mid_rst_busy", busyMask, 32'h0);
    chk("mid_rst_err", 32'(errUnderflow), 32'h0);
    chk("mid_rst_stallCount", 32'(stallCount), 32'h0);
    chk("mid_rst_r3_ready", 32'(stall), 32'h0);

    // Randomized traffic on a narrow register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      nx();
      reset      = ($urandom_range(0, 249) == 0);
      issueValid = ($urandom_range(0, 3) != 0);
      useRs      = $urandom_range(0, 1);
      useRt      = $urandom_range(0, 1);
      issueRs    = 5'($urandom_range(0, 7));
      issueRt    = 5'($urandom_range(0, 7));
      issueWrite = ($urandom_range(0, 2) != 0);
      issueDst   = 5'($urandom_range(0, 7));
      wbValid    = ($urandom_range(0, 2) == 0);
      wbIdx      = 5'($urandom_range(0, 7));
      killValid  = ($urandom_range(0, 9) == 0);
      killIdx    = 5'($urandom_range(0, 7));
    end
    nx(); reset = 0;
    repeat (3) go();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Issue-stage hazard controller for the 32-entry register file. Tracks outstanding writes per architectural register with small saturating counters. Stalls decode when a source operand or the destination counter is not ready. Releases entries on writeback or on squash of in-flight instructions. Replaces per-register single-bit ready flags, so multiple outstanding writes to one register (WAW) and pipeline flushes are handled correctly.

## Interface
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- IDX_W, 5, register index width.
- CNT_W, 2, pending-write counter width; at most 2^CNT_W-1 outstanding writes per register.
- WB_BYPASS, 1, when 1, a writeback releasing the last pending write makes that register readable in the same cycle (register file is write-through).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- issueValid  in  1  decode presents an instruction this cycle.
- useRs, useRt  in  1 each  instruction reads Rs / Rt.
- issueRs, issueRt  in  IDX_W each  source register indices.
- issueWrite  in  1  instruction writes a destination register.
- issueDst  in  IDX_W  destination index (already muxed Rt/Rd by regDst).
- wbValid  in  1  writeback-stage register write this cycle.
- wbIdx  in  IDX_W  writeback destination.
- killValid  in  1  an in-flight writing instruction is squashed; releases one pending write without writing.
- killIdx  in  IDX_W  destination of the squashed instruction.
- stall  out  1  combinational; decode must hold the instruction.
- issueAccept  out  1  combinational; issueValid & ~stall.
- busyMask  out  NUM_REGS  registered; bit n = counter[n] != 0; bit 0 always 0.
- errUnderflow  out  1  registered, sticky; release seen on a register whose counter was 0.
- stallCount  out  16  registered; saturating count of cycles with issueValid & stall.

## Operation
- State: counter[1..NUM_REGS-1] of CNT_W bits; counter[0] does not exist and reads 0.
- A source is ready when its use bit is 0, or its index is 0, or its counter is 0. With WB_BYPASS=1, a source is also ready when its counter is 1 and wbValid & wbIdx equals that source.
  - Kill never bypasses.
- Destination blocks when issueWrite is set, issueDst is nonzero, and counter[issueDst] equals the maximum (2^CNT_W-1). A same-cycle release to issueDst does not unblock.
- stall = issueValid & (Rs not ready | Rt not ready | destination blocks).
- Per-register next count, for n nonzero: counter + inc - relWb - relKill.
  - inc = issueAccept & issueWrite & (issueDst==n).
  - relWb = wbValid & (wbIdx==n).
  - relKill = killValid & (killIdx==n).
  - Wb and kill to the same register in one cycle release 2.
- Underflow: if the releases exceed counter+inc, counter clamps to 0 and errUnderflow sets. errUnderflow clears only on reset.
- Index 0 on issue, wb or kill: ignored; no count change, no error.
- No issue is accepted while stall is high; the stalled instruction changes no state.
- stallCount increments by 1 per stalled cycle and saturates at 16'hFFFF.

## Timing
- stall and issueAccept are combinational from the current counters and the same-cycle inputs. There are no combinational paths from stall to other outputs.
- Counter updates take effect at the next rising edge. busyMask, errUnderflow and stallCount reflect post-edge state.
- Issue-to-busy latency is 1 cycle: a write accepted in cycle t shows busyMask[dst]=1 from cycle t+1.
- Wb-to-ready: same cycle with WB_BYPASS=1, otherwise the next cycle.
- Simultaneous accepted issue and release on the same register leaves the count unchanged.
- Reset (sampled high at an edge) forces all counters, busyMask, errUnderflow and stallCount to 0. All same-cycle issue, wb and kill inputs are discarded. Mid-operation reset drops all pending writes.
- While reset is high, stall is still computed from the (zero) counters. Decode is responsible for gating issueValid.

## Test plan
- RAW: accept a write to r3 in cycle 0. Issue a read of r3 in cycles 1-3 -> stall=1, stallCount=3. wb r3 in cycle 4 -> stall=0 in cycle 4 (bypass), busyMask[3]=0 in cycle 5.
- WAW: accept 3 writes to r5 -> counter 3, 4th write stalls. One wb r5 -> 4th accepted the next cycle. busyMask[5] stays 1 until 3 more wbs.
- r0: issue write to r0, then read r0 -> never stall, busyMask=0. wb/kill r0 -> errUnderflow stays 0.
- Flush: accept writes to r7 and r8, then kill r7 and kill r8 in consecutive cycles -> busyMask=0. Extra kill r7 -> errUnderflow=1 (sticky), counter[7] stays 0.
- Simultaneous: counter[9]=1; same cycle accepted issue to r9 plus wb r9 -> counter[9] remains 1. Wb plus kill on r9 at counter 2 -> 0.
- Reset mid-operation: busyMask=0x0000_0118, stallCount=5, then reset with wbValid high -> all outputs 0 next cycle. Read of r3 no longer stalls.
